// File: rtl/core_idecode_pkg.sv
// core_idecode_pkg: opcode/funct constants, decoded bundle and pipe state shared by the decode stage.
package core_idecode_pkg;
   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;
   localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
   localparam logic [6:0] OPCODE_R_OP   = 7'b0110011;
   localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
   localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
   localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;
   localparam logic [2:0] FUNCT3_ADD    = 3'b000;
   localparam logic [2:0] FUNCT3_SLL    = 3'b001;
   localparam logic [2:0] FUNCT3_SR     = 3'b101;
   localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;

   typedef struct packed {
      logic [6:0] opcode;
      logic [2:0] funct3;
      logic [6:0] funct7;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       rd_we;
      logic       is_imm;
      logic       illegal;
   } dec_t;

   // encoding is {main_valid, skid_valid}
   typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b10, FULL = 2'b11} state_t;
endpackage

// File: rtl/core_idecode_comb.sv
// core_idecode_comb: pure combinational RV32I/RV64I decode of fields, immediate, operand select, write enable and legality.
module core_idecode_comb
   import core_idecode_pkg::*;
#(
   parameter int XLEN = 32,
   parameter logic [XLEN-1:0] BAD_IMM = {XLEN/32{32'hDEADBEEF}}
) (
   input  logic [31:0]     instr,
   output dec_t            dec,
   output logic [XLEN-1:0] imm
);
   logic [6:0] op;
   logic [2:0] f3;
   logic [6:0] f7;
   logic [6:0] shf7;
   logic       known;
   logic       illegal;
   logic       use_i;
   logic       use_u;
   logic       writes;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] imm_b;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] imm_j;

   assign op = instr[6:0];
   assign f3 = instr[14:12];
   assign f7 = instr[31:25];
   // RV64 shift amounts borrow instr[25], so only the upper six bits qualify the shift
   assign shf7 = (XLEN == 64) ? {instr[31:26], 1'b0} : f7;

   assign known = op inside {OPCODE_OP_IMM, OPCODE_R_OP, OPCODE_LOAD, OPCODE_STORE, OPCODE_BRANCH,
                             OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR, OPCODE_FENCE, OPCODE_SYSTEM};

   assign illegal = !known
      || (op == OPCODE_BRANCH && f3 inside {3'b010, 3'b011})
      || (op == OPCODE_LOAD && ((XLEN == 32) ? f3 inside {3'b011, 3'b110, 3'b111} : f3 == 3'b111))
      || (op == OPCODE_STORE && f3 > ((XLEN == 32) ? 3'b010 : 3'b011))
      || (op == OPCODE_JALR && f3 != FUNCT3_ADD)
      || (op == OPCODE_R_OP && !(f7 == 7'b0 || (f7 == FUNCT7_ALT && f3 inside {FUNCT3_ADD, FUNCT3_SR})))
      || (op == OPCODE_OP_IMM && ((f3 == FUNCT3_SLL && shf7 != 7'b0)
                               || (f3 == FUNCT3_SR && shf7 != 7'b0 && shf7 != FUNCT7_ALT)));

   assign imm_i = XLEN'($signed(instr[31:20]));
   assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
   assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
   assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
   assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

   assign use_i  = op inside {OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_JALR};
   assign use_u  = op inside {OPCODE_LUI, OPCODE_AUIPC};
   assign writes = op inside {OPCODE_OP_IMM, OPCODE_R_OP, OPCODE_LOAD, OPCODE_JALR, OPCODE_JAL,
                              OPCODE_LUI, OPCODE_AUIPC};

   assign imm = illegal                ? BAD_IMM :
                use_i                  ? imm_i   :
                op == OPCODE_STORE     ? imm_s   :
                op == OPCODE_BRANCH    ? imm_b   :
                use_u                  ? imm_u   :
                op == OPCODE_JAL       ? imm_j   : BAD_IMM;

   assign dec.opcode  = op;
   assign dec.funct3  = f3;
   assign dec.funct7  = f7;
   assign dec.rs1     = instr[19:15];
   assign dec.rs2     = instr[24:20];
   assign dec.rd      = instr[11:7];
   assign dec.rd_we   = writes && instr[11:7] != 5'd0 && !illegal;
   assign dec.is_imm  = use_i || use_u || op inside {OPCODE_STORE, OPCODE_JAL};
   assign dec.illegal = illegal;
endmodule

// File: rtl/core_idecode_pipe.sv
// core_idecode_pipe: elastic decode stage with a main register and a one-entry skid buffer.
module core_idecode_pipe
   import core_idecode_pkg::*;
#(
   parameter int XLEN = 32,
   parameter logic [XLEN-1:0] BAD_IMM = {XLEN/32{32'hDEADBEEF}}
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            IN_VALID,
   output logic            IN_READY,
   input  logic [31:0]     IN_INSTR,
   input  logic [XLEN-1:0] IN_PC,
   input  logic            FLUSH,
   output logic            OUT_VALID,
   input  logic            OUT_READY,
   output logic [XLEN-1:0] OUT_PC,
   output logic [6:0]      OUT_OPCODE,
   output logic [2:0]      OUT_FUNCT3,
   output logic [6:0]      OUT_FUNCT7,
   output logic [4:0]      OUT_RS1,
   output logic [4:0]      OUT_RS2,
   output logic [4:0]      OUT_RD,
   output logic            OUT_RD_WE,
   output logic            OUT_IS_IMM,
   output logic [XLEN-1:0] OUT_IMM,
   output logic            OUT_ILLEGAL
);
   state_t          state;
   state_t          nxt;
   dec_t            dec;
   dec_t            main_dec;
   dec_t            skid_dec;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] main_imm;
   logic [XLEN-1:0] skid_imm;
   logic [XLEN-1:0] main_pc;
   logic [XLEN-1:0] skid_pc;
   logic            in_xfer;
   logic            out_xfer;
   logic            ld_main;
   logic            ld_skid;
   logic            mv_skid;

   core_idecode_comb #(.XLEN(XLEN), .BAD_IMM(BAD_IMM)) u_comb (
      .instr (IN_INSTR),
      .dec   (dec),
      .imm   (imm)
   );

   // ready depends only on registered state, never on OUT_READY
   assign IN_READY  = state != FULL && !RST;
   assign OUT_VALID = state[1];
   assign in_xfer   = IN_VALID && IN_READY && !FLUSH;
   assign out_xfer  = OUT_VALID && OUT_READY;

   always_ff @(posedge CLK or posedge RST)
      if (RST) state <= EMPTY;
      else     state <= nxt;

   always_comb begin
      nxt     = state;
      ld_main = 1'b0;
      ld_skid = 1'b0;
      mv_skid = 1'b0;
      case (state)
         EMPTY: begin
            nxt     = in_xfer ? ONE : EMPTY;
            ld_main = in_xfer;
         end
         ONE: begin
            nxt     = (in_xfer && !out_xfer) ? FULL : (!in_xfer && out_xfer) ? EMPTY : ONE;
            ld_main = in_xfer && out_xfer;
            ld_skid = in_xfer && !out_xfer;
         end
         FULL: begin
            nxt     = out_xfer ? ONE : FULL;
            mv_skid = out_xfer;
         end
         default: nxt = EMPTY;
      endcase
      if (FLUSH) nxt = EMPTY;
   end

   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         main_dec <= '0;
         main_imm <= BAD_IMM;
         main_pc  <= '0;
         skid_dec <= '0;
         skid_imm <= BAD_IMM;
         skid_pc  <= '0;
      end else begin
         if (ld_main) begin
            main_dec <= dec;
            main_imm <= imm;
            main_pc  <= IN_PC;
         end else if (mv_skid) begin
            main_dec <= skid_dec;
            main_imm <= skid_imm;
            main_pc  <= skid_pc;
         end
         if (ld_skid) begin
            skid_dec <= dec;
            skid_imm <= imm;
            skid_pc  <= IN_PC;
         end
      end

   assign OUT_PC      = main_pc;
   assign OUT_OPCODE  = main_dec.opcode;
   assign OUT_FUNCT3  = main_dec.funct3;
   assign OUT_FUNCT7  = main_dec.funct7;
   assign OUT_RS1     = main_dec.rs1;
   assign OUT_RS2     = main_dec.rs2;
   assign OUT_RD      = main_dec.rd;
   assign OUT_RD_WE   = main_dec.rd_we;
   assign OUT_IS_IMM  = main_dec.is_imm;
   assign OUT_IMM     = main_imm;
   assign OUT_ILLEGAL = main_dec.illegal;
endmodule

// File: tb/tb_core_idecode_pipe.sv
// tb_core_idecode_pipe: directed checks of an RV32 and an RV64 decode stage sharing one input stream.
module tb_core_idecode_pipe;
   logic        clk = 1'b0;
   logic        rst32, rst64;
   logic        in_valid, flush, out_ready;
   logic [31:0] in_instr;
   logic [63:0] in_pc;
   int          total = 0;
   int          bad = 0;

   logic        a_in_ready, a_out_valid, a_rd_we, a_is_imm, a_illegal;
   logic [31:0] a_pc, a_imm;
   logic [6:0]  a_opcode, a_funct7;
   logic [2:0]  a_funct3;
   logic [4:0]  a_rs1, a_rs2, a_rd;

   logic        b_in_ready, b_out_valid, b_rd_we, b_is_imm, b_illegal;
   logic [63:0] b_pc, b_imm;
   logic [6:0]  b_opcode, b_funct7;
   logic [2:0]  b_funct3;
   logic [4:0]  b_rs1, b_rs2, b_rd;

   always #5 clk = ~clk;

   core_idecode_pipe #(.XLEN(32)) d32 (
      .CLK(clk), .RST(rst32), .IN_VALID(in_valid), .IN_READY(a_in_ready), .IN_INSTR(in_instr),
      .IN_PC(in_pc[31:0]), .FLUSH(flush), .OUT_VALID(a_out_valid), .OUT_READY(out_ready),
      .OUT_PC(a_pc), .OUT_OPCODE(a_opcode), .OUT_FUNCT3(a_funct3), .OUT_FUNCT7(a_funct7),
      .OUT_RS1(a_rs1), .OUT_RS2(a_rs2), .OUT_RD(a_rd), .OUT_RD_WE(a_rd_we),
      .OUT_IS_IMM(a_is_imm), .OUT_IMM(a_imm), .OUT_ILLEGAL(a_illegal)
   );

   core_idecode_pipe #(.XLEN(64)) d64 (
      .CLK(clk), .RST(rst64), .IN_VALID(in_valid), .IN_READY(b_in_ready), .IN_INSTR(in_instr),
      .IN_PC(in_pc), .FLUSH(flush), .OUT_VALID(b_out_valid), .OUT_READY(out_ready),
      .OUT_PC(b_pc), .OUT_OPCODE(b_opcode), .OUT_FUNCT3(b_funct3), .OUT_FUNCT7(b_funct7),
      .OUT_RS1(b_rs1), .OUT_RS2(b_rs2), .OUT_RD(b_rd), .OUT_RD_WE(b_rd_we),
      .OUT_IS_IMM(b_is_imm), .OUT_IMM(b_imm), .OUT_ILLEGAL(b_illegal)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] ins, input logic [63:0] pc);
      in_valid = 1'b1;
      in_instr = ins;
      in_pc    = pc;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      rst32 = 1'b1; rst64 = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      in_instr = 32'h0; in_pc = 64'h0;
      tick();
      tick();
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_in_ready", a_in_ready, 0);
      chk("rst_imm", a_imm, 64'hDEADBEEF);
      chk("rst_imm64", b_imm, 64'hDEADBEEFDEADBEEF);
      chk("rst_pc", a_pc, 0);
      chk("rst_rd", a_rd, 0);
      chk("rst_rd_we", a_rd_we, 0);
      chk("rst_illegal", a_illegal, 0);
      rst32 = 1'b0; rst64 = 1'b0;
      #1;
      chk("rel_in_ready", a_in_ready, 1);

      // ADDI x5,x1,-1
      out_ready = 1'b1;
      send(32'hFFF08293, 64'h100);
      chk("addi_valid", a_out_valid, 1);
      chk("addi_pc", a_pc, 32'h100);
      chk("addi_rs1", a_rs1, 1);
      chk("addi_rd", a_rd, 5);
      chk("addi_imm", a_imm, 32'hFFFFFFFF);
      chk("addi_imm64", b_imm, 64'hFFFFFFFFFFFFFFFF);
      chk("addi_is_imm", a_is_imm, 1);
      chk("addi_rd_we", a_rd_we, 1);
      chk("addi_illegal", a_illegal, 0);

      send(32'hFE000EE3, 64'h104);
      chk("beq_imm", a_imm, 32'hFFFFFFFC);
      chk("beq_is_imm", a_is_imm, 0);
      chk("beq_rd_we", a_rd_we, 0);
      chk("beq_opcode", a_opcode, 7'h63);

      send(32'h00412003, 64'h108);
      chk("lw_is_imm", a_is_imm, 1);
      chk("lw_rd_we", a_rd_we, 0);
      chk("lw_imm", a_imm, 4);
      chk("lw_rs1", a_rs1, 2);
      chk("lw_funct3", a_funct3, 3'b010);

      send(32'h00000000, 64'h10C);
      chk("zero_illegal", a_illegal, 1);
      chk("zero_imm", a_imm, 32'hDEADBEEF);
      chk("zero_rd_we", a_rd_we, 0);

      send(32'h4010D093, 64'h110);
      chk("srai_illegal", a_illegal, 0);
      chk("srai_imm", a_imm, 32'h401);
      chk("srai_funct7", a_funct7, 7'h20);
      chk("srai_rd_we", a_rd_we, 1);

      send(32'h2010D093, 64'h114);
      chk("badsra_illegal", a_illegal, 1);
      chk("badsra_illegal64", b_illegal, 1);

      // LD is only legal on RV64
      send(32'h00013083, 64'h118);
      chk("ld_illegal32", a_illegal, 1);
      chk("ld_illegal64", b_illegal, 0);
      chk("ld_rd_we64", b_rd_we, 1);

      // SLLI x1,x1,32: shamt bit 25 is legal only on RV64
      send(32'h02009093, 64'h11C);
      chk("slli32_illegal32", a_illegal, 1);
      chk("slli32_illegal64", b_illegal, 0);
      chk("slli32_imm64", b_imm, 64'h20);

      send(32'h40001033, 64'h120);
      chk("subsll_illegal", a_illegal, 1);

      send(32'h800000B7, 64'h124);
      chk("lui_imm32", a_imm, 32'h80000000);
      chk("lui_imm64", b_imm, 64'hFFFFFFFF80000000);
      chk("lui_rd_we", b_rd_we, 1);
      chk("lui_is_imm", b_is_imm, 1);
      tick();
      chk("drain_valid", a_out_valid, 0);

      // stall stream: OUT_READY low across three edges
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 64'h200;
      tick();
      chk("st1_pc", a_pc, 32'h200);
      chk("st1_in_ready", a_in_ready, 1);
      in_instr = 32'h00200113; in_pc = 64'h204;
      tick();
      chk("st2_in_ready", a_in_ready, 0);
      chk("st2_pc", a_pc, 32'h200);
      in_instr = 32'h00300193; in_pc = 64'h208;
      tick();
      chk("st3_in_ready", a_in_ready, 0);
      chk("st3_pc", a_pc, 32'h200);
      chk("st3_rd", a_rd, 1);
      out_ready = 1'b1;
      tick();
      chk("st4_pc", a_pc, 32'h204);
      chk("st4_rd", a_rd, 2);
      chk("st4_in_ready", a_in_ready, 1);
      tick();
      chk("st5_pc", a_pc, 32'h208);
      chk("st5_imm", a_imm, 3);
      in_instr = 32'h00400213; in_pc = 64'h20C;
      tick();
      chk("st6_pc", a_pc, 32'h20C);
      chk("st6_valid", a_out_valid, 1);
      in_valid = 1'b0;
      tick();
      chk("st7_valid", a_out_valid, 0);

      // flush while FULL with an instruction offered
      out_ready = 1'b0;
      send(32'h00100093, 64'h300);
      send(32'h00200113, 64'h304);
      chk("fl_full", a_in_ready, 0);
      in_valid = 1'b1; in_instr = 32'h00300193; in_pc = 64'h308; flush = 1'b1;
      tick();
      chk("fl_valid", a_out_valid, 0);
      chk("fl_in_ready", a_in_ready, 1);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk("fl_after_valid", a_out_valid, 0);

      // flush in ONE drops the offered input
      out_ready = 1'b0;
      send(32'h00100093, 64'h310);
      in_valid = 1'b1; in_pc = 64'h314; flush = 1'b1;
      tick();
      chk("fl1_valid", a_out_valid, 0);
      flush = 1'b0; in_valid = 1'b0;
      tick();
      chk("fl1_after_valid", a_out_valid, 0);

      // asynchronous reset of the RV64 stage while FULL
      send(32'h800000B7, 64'h400);
      send(32'h00200113, 64'h404);
      chk("ar_full", b_in_ready, 0);
      chk("ar_valid_before", b_out_valid, 1);
      #2 rst64 = 1'b1;
      #1;
      chk("ar_out_valid", b_out_valid, 0);
      chk("ar_in_ready", b_in_ready, 0);
      chk("ar_imm", b_imm, 64'hDEADBEEFDEADBEEF);
      tick();
      rst64 = 1'b0;
      #1;
      chk("ar_rel_ready", b_in_ready, 1);
      chk("ar_rel_valid", b_out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
